// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: register-address width,
// controller state encoding and the bundle of pipeline control strobes.
package hazard_ctrl_pkg;

    localparam int ADDR_WIDTH = 5;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_HALT     = 2'd2
    } state_e;

    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic if_id_flush;
        logic id_ex_write;
        logic id_ex_flush;
        logic ex_mem_stall;
    } ctrl_t;

    function automatic ctrl_t ctrl_run();
        return '{pc_write: 1'b1, if_id_write: 1'b1, if_id_flush: 1'b0,
                 id_ex_write: 1'b1, id_ex_flush: 1'b0, ex_mem_stall: 1'b0};
    endfunction

    // Whole pipeline held in place; used for data-memory wait and for halt.
    function automatic ctrl_t ctrl_freeze();
        return '{pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b0,
                 id_ex_write: 1'b0, id_ex_flush: 1'b0, ex_mem_stall: 1'b1};
    endfunction

    function automatic ctrl_t ctrl_redirect();
        return '{pc_write: 1'b1, if_id_write: 1'b1, if_id_flush: 1'b1,
                 id_ex_write: 1'b1, id_ex_flush: 1'b1, ex_mem_stall: 1'b0};
    endfunction

    // Hold PC and IF/ID, load a bubble into ID/EX.
    function automatic ctrl_t ctrl_load_use();
        return '{pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b0,
                 id_ex_write: 1'b1, id_ex_flush: 1'b1, ex_mem_stall: 1'b0};
    endfunction

endpackage

// File: rtl/hazard_ctrl_detect.sv
// Combinational load-use detector: a load in EX whose destination is read by
// the instruction in ID.
module hazard_detect
    import hazard_ctrl_pkg::*;
(
    input  logic [ADDR_WIDTH-1:0] id_rs1_addr_i,
    input  logic [ADDR_WIDTH-1:0] id_rs2_addr_i,
    input  logic                  id_rs1_used_i,
    input  logic                  id_rs2_used_i,
    input  logic                  ex_mem_r_i,
    input  logic [ADDR_WIDTH-1:0] ex_rd_addr_i,
    output logic                  load_use_o
);

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit = id_rs1_used_i && (id_rs1_addr_i == ex_rd_addr_i);
    assign rs2_hit = id_rs2_used_i && (id_rs2_addr_i == ex_rd_addr_i);

    // x0 is hard-wired zero, so a load targeting it never creates a dependency.
    assign load_use_o = ex_mem_r_i && (ex_rd_addr_i != '0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, redirect flushes, data-memory
// wait freezing with timeout halt, and a saturating stall counter.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] ID_Rs1_Addr,
    input  logic [ADDR_WIDTH-1:0] ID_Rs2_Addr,
    input  logic                  ID_Rs1_Used,
    input  logic                  ID_Rs2_Used,
    input  logic                  EX_Mem_r,
    input  logic [ADDR_WIDTH-1:0] EX_Rd_Addr,
    input  logic                  EX_Redirect,
    input  logic                  MEM_Req,
    input  logic                  MEM_Ready,
    output logic                  PC_Write,
    output logic                  IF_ID_Write,
    output logic                  IF_ID_Flush,
    output logic                  ID_EX_Write,
    output logic                  ID_EX_Flush,
    output logic                  EX_MEM_Stall,
    output logic                  Halted,
    output logic [CNT_WIDTH-1:0]  Stall_Cnt
);

    localparam int                WAIT_W    = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    state_e               state_q, state_d;
    logic [WAIT_W-1:0]    wait_q, wait_d;
    logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
    ctrl_t                ctrl;
    logic                 load_use;
    logic                 mem_wait;

    hazard_detect u_detect (
        .id_rs1_addr_i (ID_Rs1_Addr),
        .id_rs2_addr_i (ID_Rs2_Addr),
        .id_rs1_used_i (ID_Rs1_Used),
        .id_rs2_used_i (ID_Rs2_Used),
        .ex_mem_r_i    (EX_Mem_r),
        .ex_rd_addr_i  (EX_Rd_Addr),
        .load_use_o    (load_use)
    );

    assign mem_wait = MEM_Req && !MEM_Ready;

    // NOTE: every signal written here gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    always_comb begin
        ctrl    = ctrl_run();
        state_d = state_q;
        wait_d  = '0;
        case (state_q)
            ST_HALT: ctrl = ctrl_freeze();
            default: begin
                if (mem_wait) begin
                    // A redirect seen now stays on EX_Redirect because EX is frozen.
                    ctrl    = ctrl_freeze();
                    wait_d  = wait_q + 1'b1;
                    state_d = (wait_q == WAIT_LAST) ? ST_HALT : ST_MEM_WAIT;
                end else begin
                    state_d = ST_RUN;
                    if (EX_Redirect) begin
                        ctrl = ctrl_redirect();
                    end else if (load_use) begin
                        ctrl = ctrl_load_use();
                    end
                end
            end
        endcase
        if (rst) begin
            ctrl = ctrl_run();
        end

        stall_cnt_d = stall_cnt_q;
        if (!ctrl.pc_write && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_RUN;
            wait_q      <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign PC_Write     = ctrl.pc_write;
    assign IF_ID_Write  = ctrl.if_id_write;
    assign IF_ID_Flush  = ctrl.if_id_flush;
    assign ID_EX_Write  = ctrl.id_ex_write;
    assign ID_EX_Flush  = ctrl.id_ex_flush;
    assign EX_MEM_Stall = ctrl.ex_mem_stall;
    assign Halted       = (state_q == ST_HALT);
    assign Stall_Cnt    = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: expected strobes and stall count are
// queued as each cycle's stimulus is driven and compared when sampled.
module tb_hazard_ctrl;
    import hazard_ctrl_pkg::*;

    localparam int TIMEOUT = 4;
    localparam int CW      = 4;

    // {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Flush, EX_MEM_Stall, Halted}
    localparam logic [6:0] E_DEF = 7'b1101000;
    localparam logic [6:0] E_LU  = 7'b0001100;
    localparam logic [6:0] E_RD  = 7'b1111100;
    localparam logic [6:0] E_MW  = 7'b0000010;
    localparam logic [6:0] E_HL  = 7'b0000011;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [ADDR_WIDTH-1:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
    logic                  u1 = 1'b0, u2 = 1'b0, mem_r = 1'b0, redir = 1'b0;
    logic                  mreq = 1'b0, mrdy = 1'b0;
    logic                  pc_w, ifid_w, ifid_f, idex_w, idex_f, exmem_s, halted;
    logic [CW-1:0]         stall_cnt;

    int                    checks = 0;
    int                    errors = 0;
    logic [CW-1:0]         exp_cnt = '0;
    logic [6+CW:0]         exp_q[$];
    string                 tag_q[$];

    always #5 clk = ~clk;

    hazard_ctrl #(.MEM_TIMEOUT(TIMEOUT), .CNT_WIDTH(CW)) dut (
        .clk          (clk),
        .rst          (rst),
        .ID_Rs1_Addr  (id_rs1),
        .ID_Rs2_Addr  (id_rs2),
        .ID_Rs1_Used  (u1),
        .ID_Rs2_Used  (u2),
        .EX_Mem_r     (mem_r),
        .EX_Rd_Addr   (ex_rd),
        .EX_Redirect  (redir),
        .MEM_Req      (mreq),
        .MEM_Ready    (mrdy),
        .PC_Write     (pc_w),
        .IF_ID_Write  (ifid_w),
        .IF_ID_Flush  (ifid_f),
        .ID_EX_Write  (idex_w),
        .ID_EX_Flush  (idex_f),
        .EX_MEM_Stall (exmem_s),
        .Halted       (halted),
        .Stall_Cnt    (stall_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One cycle: drive inputs after the rising edge, queue the expectation,
    // sample on the falling edge and compare against the queue head.
    task automatic apply(input string tag, input logic [6:0] exp,
                         input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic use1, input logic use2, input logic ld,
                         input logic [4:0] rd, input logic rdr,
                         input logic req, input logic rdy);
        logic [6+CW:0] e;
        string         t;
        @(posedge clk);
        #1;
        id_rs1 = rs1; id_rs2 = rs2; u1 = use1; u2 = use2;
        mem_r = ld; ex_rd = rd; redir = rdr; mreq = req; mrdy = rdy;
        if (rst) exp_cnt = '0;
        exp_q.push_back({exp, exp_cnt});
        tag_q.push_back(tag);
        if (!rst && !exp[6] && (exp_cnt != '1)) exp_cnt = exp_cnt + 1'b1;
        @(negedge clk);
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        check({t, "_ctl"}, {25'd0, pc_w, ifid_w, ifid_f, idex_w, idex_f, exmem_s, halted},
              {25'd0, e[6+CW:CW]});
        check({t, "_cnt"}, {{(32-CW){1'b0}}, stall_cnt}, {{(32-CW){1'b0}}, e[CW-1:0]});
    endtask

    task automatic idle(input string tag, input logic [6:0] exp);
        apply(tag, exp, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    // Reset pulse with idle inputs; outputs are checked while rst is high.
    task automatic pulse_reset(input string tag);
        @(posedge clk);
        #1;
        rst = 1'b1;
        idle(tag, E_DEF);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        idle("reset", E_DEF);
        #1 rst = 1'b0;

        idle("idle0", E_DEF);
        // lw x5 in EX; add x6,x5,x1 in ID
        apply("lu_rs1", E_LU, 5'd5, 5'd1, 1'b1, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
        idle("after_lu", E_DEF);
        apply("lu_rs2", E_LU, 5'd3, 5'd7, 1'b1, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0);
        idle("after_lu2", E_DEF);
        apply("rd_x0", E_DEF, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        apply("rs2_unused", E_DEF, 5'd4, 5'd9, 1'b1, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0);
        apply("not_load", E_DEF, 5'd9, 5'd9, 1'b1, 1'b1, 1'b0, 5'd9, 1'b0, 1'b0, 1'b0);
        apply("redir_lu", E_RD, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
        apply("redir", E_RD, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
        apply("mw_a", E_MW, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        apply("mw_b", E_MW, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        pulse_reset("rst_in_wait");
        idle("after_rst_wait", E_DEF);

        for (int i = 0; i < 3; i++)
            apply("mw_redir", E_MW, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
        apply("ready_redir", E_RD, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1);
        idle("post_redir", E_DEF);
        apply("mw_lu", E_MW, 5'd2, 5'd0, 1'b1, 1'b0, 1'b1, 5'd2, 1'b0, 1'b1, 1'b0);
        apply("ready_lu", E_LU, 5'd2, 5'd0, 1'b1, 1'b0, 1'b1, 5'd2, 1'b0, 1'b1, 1'b1);
        idle("post_lu", E_DEF);

        for (int i = 0; i < TIMEOUT; i++)
            apply("mw_to", E_MW, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++)
            apply("halt_ready", E_HL, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++)
            apply("halt_redir", E_HL, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++)
            idle("halt_sat", E_HL);
        pulse_reset("rst_in_halt");
        idle("after_rst_halt", E_DEF);
        apply("lu_again", E_LU, 5'd0, 5'd8, 1'b0, 1'b1, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0);
        idle("final", E_DEF);

        check("sb_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
